// File: rtl/tx_ts_queue.sv
// Multi-channel TX timestamp collector: per-channel holding slots, round-robin
// arbitration into a shared first-word fall-through FIFO with drop statistics.

module tx_ts_hold #(
  parameter int D_W = 116
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_cap,
  input  logic           i_gnt,
  input  logic [D_W-1:0] i_data,
  output logic           o_pend,
  output logic [D_W-1:0] o_data,
  output logic           o_drop
);
  logic           r_pend;
  logic [D_W-1:0] r_data;
  logic           w_load;

  // A grant in the same cycle frees the slot, so the new capture can take it.
  assign w_load = i_cap & (~r_pend | i_gnt);
  assign o_drop = i_cap & r_pend & ~i_gnt;
  assign o_pend = r_pend;
  assign o_data = r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend <= 1'b0;
      r_data <= '0;
    end else begin
      if (w_load) r_data <= i_data;
      r_pend <= w_load | (r_pend & ~i_gnt);
    end
  end
endmodule

module tx_ts_queue #(
  parameter  int NUM_CH = 4,
  parameter  int DEPTH  = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic                 tx_clk,
  input  logic                 tx_rst,
  input  logic                 tx_clk_en_i,
  input  logic                 queue_en_i,
  input  logic [NUM_CH-1:0]    txts_valid_i,
  input  logic [NUM_CH*80-1:0] sfd_timestamp_i,
  input  logic [NUM_CH*16-1:0] sfd_timestamp_frac_ns_i,
  input  logic [NUM_CH*16-1:0] tx_seqId_i,
  input  logic [NUM_CH*4-1:0]  tx_messageType_i,
  input  logic                 ts_ready_i,
  input  logic [LVL_W-1:0]     int_thresh_i,
  input  logic                 stat_clr_i,
  output logic                 ts_valid_o,
  output logic [CH_W-1:0]      ts_ch_o,
  output logic [79:0]          ts_o,
  output logic [15:0]          ts_frac_ns_o,
  output logic [15:0]          ts_seqId_o,
  output logic [3:0]           ts_messageType_o,
  output logic [LVL_W-1:0]     level_o,
  output logic [15:0]          overflow_cnt_o,
  output logic [NUM_CH-1:0]    drop_ch_o,
  output logic                 int_tx_ts_o
);
  localparam int AW  = $clog2(DEPTH);
  localparam int D_W = 116;
  localparam int E_W = CH_W + D_W;

  logic [NUM_CH-1:0]          w_cap, w_gnt, w_pend, w_drop;
  logic [NUM_CH-1:0][D_W-1:0] w_cap_data, w_hold_data;
  logic [CH_W-1:0]            w_gnt_idx, r_last;
  logic                       w_push, w_pop, w_can_acc;
  logic [LVL_W-1:0]           r_level, w_level_nxt;
  logic [AW-1:0]              r_wr, r_rd;
  logic [E_W-1:0]             r_mem [DEPTH];
  logic [E_W-1:0]             w_head;
  logic [3:0]                 w_ndrop;
  logic [16:0]                w_ovf_sum;
  logic [15:0]                r_ovf;
  logic [NUM_CH-1:0]          r_drop;
  logic                       r_int;

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      assign w_cap[c]      = txts_valid_i[c] & tx_clk_en_i & queue_en_i;
      assign w_cap_data[c] = {sfd_timestamp_i[80*c +: 80], sfd_timestamp_frac_ns_i[16*c +: 16],
                              tx_seqId_i[16*c +: 16], tx_messageType_i[4*c +: 4]};
      tx_ts_hold #(.D_W(D_W)) u_hold (
        .i_clk (tx_clk),
        .i_rst (tx_rst),
        .i_cap (w_cap[c]),
        .i_gnt (w_gnt[c]),
        .i_data(w_cap_data[c]),
        .o_pend(w_pend[c]),
        .o_data(w_hold_data[c]),
        .o_drop(w_drop[c])
      );
    end
  endgenerate

  assign w_pop     = (r_level != '0) & ts_ready_i;
  assign w_can_acc = (r_level < LVL_W'(DEPTH)) | w_pop;

  // Round-robin search begins one past the last granted channel.
  always_comb begin : p_arb
    int idx;
    idx       = 0;
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_push    = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(r_last) + i) % NUM_CH;
      if (!w_push && w_can_acc && w_pend[idx]) begin
        w_push    = 1'b1;
        w_gnt_idx = CH_W'(idx);
      end
    end
    if (w_push) w_gnt[w_gnt_idx] = 1'b1;
  end

  assign w_level_nxt = r_level + LVL_W'(w_push) - LVL_W'(w_pop);

  always_comb begin
    w_ndrop = '0;
    for (int i = 0; i < NUM_CH; i++) w_ndrop = w_ndrop + 4'(w_drop[i]);
  end
  assign w_ovf_sum = {1'b0, r_ovf} + 17'(w_ndrop);

  always_ff @(posedge tx_clk) begin
    if (w_push) r_mem[r_wr] <= {w_gnt_idx, w_hold_data[w_gnt_idx]};
  end

  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_last  <= CH_W'(NUM_CH - 1);
      r_int   <= 1'b0;
      r_ovf   <= '0;
      r_drop  <= '0;
    end else begin
      if (w_push) begin
        r_wr   <= r_wr + 1'b1;
        r_last <= w_gnt_idx;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_level <= w_level_nxt;
      r_int   <= (int_thresh_i != '0) && (w_level_nxt >= int_thresh_i);
      if (stat_clr_i) begin
        r_ovf  <= '0;
        r_drop <= '0;
      end else begin
        r_ovf  <= w_ovf_sum[16] ? 16'hFFFF : w_ovf_sum[15:0];
        r_drop <= r_drop | w_drop;
      end
    end
  end

  // Head is forced to zero when empty so stale memory never leaks out.
  assign w_head           = ts_valid_o ? r_mem[r_rd] : '0;
  assign ts_valid_o       = (r_level != '0);
  assign ts_ch_o          = w_head[E_W-1 -: CH_W];
  assign ts_o             = w_head[115:36];
  assign ts_frac_ns_o     = w_head[35:20];
  assign ts_seqId_o       = w_head[19:4];
  assign ts_messageType_o = w_head[3:0];
  assign level_o          = r_level;
  assign overflow_cnt_o   = r_ovf;
  assign drop_ch_o        = r_drop;
  assign int_tx_ts_o      = r_int;
endmodule
